digit_serial_adder: RTL and testbench

Parametrised, multi-cycle successor to the fixed 16-bit ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, with a registered carry between digits. A start/busy/done handshake trades latency for area in datapaths where a full-width ripple chain is too long or too large. Results are registered and held until the next operation.

---
 rtl/digit_serial_adder_if.sv | 33 +++
 rtl/digit_serial_adder.sv | 147 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// Handshake/operand bundle for digit_serial_adder.
// The sub signal exists only when DIGIT_SERIAL_SUB_EN is defined.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef DIGIT_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
`ifdef DIGIT_SERIAL_SUB_EN
    output sub,
`endif
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef DIGIT_SERIAL_SUB_EN
    input  sub,
`endif
    output busy, done, s, c_out
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, with a registered carry between digits. Start/busy/done
// handshake; result registered and held until the next operation.
// Optional feature macro: DIGIT_SERIAL_SUB_EN (adds sub port, a - b - c_in).
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  digit_serial_adder_if.slave bus
);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_width_check
    $error("digit_serial_adder: WIDTH must be >= 1");
  end
  if (DIGIT < 1) begin : g_digit_check
    $error("digit_serial_adder: DIGIT must be >= 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_div_check
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  localparam int K  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(K - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             c_out_r;

  logic             accept;
  logic             last;
  logic             busy;
  logic             done;
  logic             sub_sel;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   digit_sum;

`ifdef DIGIT_SERIAL_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode, accept strobe and handshake outputs.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Single DIGIT-bit adder on the digit selected by cnt; digits are picked
  // with shifts so K=1 needs no special-case part-selects.
  always_comb begin
    base      = 32'(cnt) * 32'(DIGIT);
    a_dig     = DIGIT'(a_r >> base);
    b_dig     = DIGIT'(b_r >> base);
    digit_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
  end

  // Operand capture and per-digit accumulation. Subtraction stores ~b and
  // starts the carry at ~c_in, so the same adder yields a - b - c_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= sub_sel ? ~bus.b : bus.b;
      carry <= bus.c_in ^ sub_sel;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_r <= (sum_r & ~(DMASK << base)) |
               (WIDTH'(digit_sum[DIGIT-1:0]) << base);
      carry <= digit_sum[DIGIT];
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        c_out_r <= digit_sum[DIGIT];
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.s     = sum_r;
  assign bus.c_out = c_out_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed vectors on a 16/4
// instance checked by a cycle-level reference model, plus 16/16, 8/1 and
// 12/3 instances exercised with random operands.
module tb_digit_serial_adder;

  localparam int K = 4;

  logic clk = 1'b0;
  logic rst;
  logic sub_v;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(16)) bus0 ();
  digit_serial_adder_if #(.WIDTH(16)) bus1 ();
  digit_serial_adder_if #(.WIDTH(8))  bus2 ();
  digit_serial_adder_if #(.WIDTH(12)) bus3 ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));
  digit_serial_adder #(.WIDTH(12), .DIGIT(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

`ifdef DIGIT_SERIAL_SUB_EN
  assign bus0.sub = sub_v;
  assign bus1.sub = 1'b0;
  assign bus2.sub = 1'b0;
  assign bus3.sub = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + 17'(~ci);
    return {1'b0, a} + {1'b0, b} + 17'(ci);
  endfunction

  // Reference model: phase = cycles since acceptance (-1 when idle).
  int          m_phase = -1;
  logic [16:0] m_exp   = '0;
  logic [16:0] m_last  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = -1;
      m_last  = '0;
    end else begin
      if ((m_phase == -1 || m_phase == K) && bus0.start) begin
        m_exp   = ref_sum(bus0.a, bus0.b, bus0.c_in, sub_v);
        m_phase = 0;
      end else if (m_phase == K) begin
        m_phase = -1;
      end else if (m_phase >= 0) begin
        m_phase++;
      end
      if (m_phase == K) m_last = m_exp;
    end
    #1;
    check("model busy", 32'(bus0.busy), 32'(m_phase >= 0 && m_phase < K));
    check("model done", 32'(bus0.done), 32'(m_phase == K));
    if (m_phase == -1 || m_phase == K)
      check("model result", 32'({bus0.c_out, bus0.s}), 32'(m_last));
  end

  // Drives one operation on bus0 from a negedge; returns on the done negedge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input int poke, output int lat, output int busy_n);
    bus0.start = 1'b1;
    bus0.a     = a;
    bus0.b     = b;
    bus0.c_in  = ci;
    sub_v      = sb;
    lat        = 0;
    busy_n     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus0.a    = 16'($urandom);
        bus0.b    = 16'($urandom);
        bus0.c_in = 1'($urandom);
        sub_v     = 1'($urandom);
      end
      if (bus0.done) begin
        lat = i;
        break;
      end
      if (bus0.busy) busy_n++;
      bus0.start = (i == poke);
    end
    bus0.start = 1'b0;
    sub_v      = 1'b0;
  endtask

  task automatic run_variants(input int rounds);
    logic [15:0] a1, b1;
    logic [7:0]  a2, b2;
    logic [11:0] a3, b3;
    logic        c1, c2, c3;
    int          g1, g2, g3;
    for (int r = 0; r < rounds; r++) begin
      a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
      a2 = 8'($urandom);  b2 = 8'($urandom);  c2 = 1'($urandom);
      a3 = 12'($urandom); b3 = 12'($urandom); c3 = 1'($urandom);
      if (r == 0) begin
        a1 = '1; b1 = '1; c1 = 1'b1;
        a2 = '1; b2 = '1; c2 = 1'b1;
        a3 = '1; b3 = '1; c3 = 1'b1;
      end
      bus1.a = a1; bus1.b = b1; bus1.c_in = c1; bus1.start = 1'b1;
      bus2.a = a2; bus2.b = b2; bus2.c_in = c2; bus2.start = 1'b1;
      bus3.a = a3; bus3.b = b3; bus3.c_in = c3; bus3.start = 1'b1;
      g1 = 0; g2 = 0; g3 = 0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        bus1.start = 1'b0; bus2.start = 1'b0; bus3.start = 1'b0;
        if (bus1.done && g1 == 0) begin
          g1 = i;
          check("w16d16 sum", 32'({bus1.c_out, bus1.s}), 32'({1'b0, a1} + {1'b0, b1} + 17'(c1)));
        end
        if (bus2.done && g2 == 0) begin
          g2 = i;
          check("w8d1 sum", 32'({bus2.c_out, bus2.s}), 32'({1'b0, a2} + {1'b0, b2} + 9'(c2)));
        end
        if (bus3.done && g3 == 0) begin
          g3 = i;
          check("w12d3 sum", 32'({bus3.c_out, bus3.s}), 32'({1'b0, a3} + {1'b0, b3} + 13'(c3)));
        end
      end
      check("w16d16 latency", 32'(g1), 32'd2);
      check("w8d1 latency",   32'(g2), 32'd9);
      check("w12d3 latency",  32'(g3), 32'd5);
    end
  endtask

  initial begin
    int lat, bn, extra;
    rst = 1'b1;
    sub_v = 1'b0;
    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c_in = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done), 32'd0);
    check("reset s", 32'(bus0.s), 32'h0);
    check("reset c_out", 32'(bus0.c_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // FFFF + 0000 + 1: carry ripples through every digit.
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, lat, bn);
    check("t1 busy cycles", 32'(bn), 32'd4);
    check("t1 latency", 32'(lat), 32'd5);
    check("t1 s", 32'(bus0.s), 32'h0000);
    check("t1 c_out", 32'(bus0.c_out), 32'd1);
    @(negedge clk);

    // 1234 + 4321 with a start pulse during RUN that must be ignored.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 2, lat, bn);
    check("t2 latency", 32'(lat), 32'd5);
    check("t2 s", 32'(bus0.s), 32'h5555);
    check("t2 c_out", 32'(bus0.c_out), 32'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.done) extra++;
    end
    check("t2 extra done", 32'(extra), 32'd0);

    // Back-to-back: second start issued in the done cycle.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, lat, bn);
    check("t3a s", 32'(bus0.s), 32'hFFFF);
    check("t3a c_out", 32'(bus0.c_out), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, lat, bn);
    check("t3b latency", 32'(lat), 32'd5);
    check("t3b s", 32'(bus0.s), 32'h0002);
    check("t3b c_out", 32'(bus0.c_out), 32'd0);
    @(negedge clk);

    // Leave c_out=1 and s=FFFF so the mid-run reset visibly clears them.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, lat, bn);
    @(negedge clk);
    bus0.a = 16'h8000; bus0.b = 16'h8000; bus0.c_in = 1'b0; bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    check("t4 pre-reset busy", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t4 async busy", 32'(bus0.busy), 32'd0);
    check("t4 async done", 32'(bus0.done), 32'd0);
    check("t4 async s", 32'(bus0.s), 32'h0);
    check("t4 async c_out", 32'(bus0.c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, lat, bn);
    check("t4 latency", 32'(lat), 32'd5);
    check("t4 s", 32'(bus0.s), 32'h0000);
    check("t4 c_out", 32'(bus0.c_out), 32'd1);
    @(negedge clk);

`ifdef DIGIT_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, lat, bn);
    check("sub1 s", 32'(bus0.s), 32'hFFFE);
    check("sub1 c_out", 32'(bus0.c_out), 32'd0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, lat, bn);
    check("sub2 s", 32'(bus0.s), 32'h0001);
    check("sub2 c_out", 32'(bus0.c_out), 32'd1);
    @(negedge clk);
`endif

    // Zero operands, then random operations checked by the model.
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, lat, bn);
    check("zero s", 32'(bus0.s), 32'h0);
    check("zero c_out", 32'(bus0.c_out), 32'd0);
    for (int n = 0; n < 12; n++) begin
      logic sb;
`ifdef DIGIT_SERIAL_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run_op(16'($urandom), 16'($urandom), 1'($urandom), sb, 0, lat, bn);
      check("rand latency", 32'(lat), 32'd5);
      if (n % 3 == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    run_variants(10);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
